ecg_bram_writer: RTL and testbench

//  Upstream feeder for the dual-port ECG sample BRAM (4096 x 32). Captures one frame of FRAME_LEN
//  ECG samples from the acquisition/filter stage and writes them through BRAM port A
//  (Addra/Dina/Ena/Wea) at consecutive addresses, wrapping modulo 2^ADDR_W.

---
 rtl/ecg_pkg.sv | 16 +
 rtl/ecg_bram_writer_if.sv | 32 +++
 rtl/ecg_bram_writer.sv | 121 ++++++++++++
 tb/tb_ecg_bram_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared ECG sample-memory definitions: BRAM geometry and the port-A writer state encoding.
// Also imported by the port-B reader, so keep edits backward compatible.
package ecg_pkg;

    localparam int ECG_ADDR_W = 12;
    localparam int ECG_DATA_W = 32;
    localparam int ECG_DEPTH  = 1 << ECG_ADDR_W;
    localparam int ECG_CNT_W  = ECG_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FINISH  = 2'd2
    } ecg_state_t;

endpackage

// File: rtl/ecg_bram_writer_if.sv
// Control, sample stream and BRAM port-A bundle of the ECG frame writer.
// master = the writer itself; slave = the surrounding system (acquisition source, BRAM, status).
interface ecg_bram_writer_if #(
    parameter int ADDR_W = ecg_pkg::ECG_ADDR_W,
    parameter int DATA_W = ecg_pkg::ECG_DATA_W
);

    logic              start;
    logic              abort;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              ena;
    logic              wea;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              overrun;

    modport master (
        input  start, abort, sample, sample_valid,
        output sample_ready, addra, dina, ena, wea, busy, done, count, overrun
    );

    modport slave (
        output start, abort, sample, sample_valid,
        input  sample_ready, addra, dina, ena, wea, busy, done, count, overrun
    );

endinterface

// File: rtl/ecg_bram_writer.sv
// Captures one frame of FRAME_LEN samples into BRAM port A at BASE_ADDR.. (mod 2^ADDR_W).
// Latency: sample accepted in cycle t is written (ena/wea) in t+1; done one cycle after FINISH.
// Backpressure: none possible upstream; samples offered while not capturing are dropped and flag overrun.
module ecg_bram_writer
    import ecg_pkg::*;
#(
    parameter int ADDR_W    = ECG_ADDR_W,
    parameter int DATA_W    = ECG_DATA_W,
    parameter int FRAME_LEN = 1 << ECG_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    ecg_bram_writer_if.master bus
);

    localparam int                CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    ecg_state_t        state_q;
    ecg_state_t        state_d;

    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic [CNT_W-1:0]  count_q;
    logic              overrun_q;
    logic              started_q;

    logic              start_frame;
    logic              accept;
    logic              last_accept;
    logic              drop;

    // count_q doubles as the write index: it equals the number of accepts so far.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        accept      = bus.sample_valid && ready_q;
        last_accept = accept && (count_q == LAST_IDX);
        drop        = bus.sample_valid && !ready_q && started_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    start_frame = 1'b1;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (last_accept) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_CAPTURE);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_FINISH) && !bus.abort;
            wea_q   <= accept;

            // An accept in an abort cycle is still committed to memory.
            if (accept) begin
                addra_q <= BASE + count_q[ADDR_W-1:0];
                dina_q  <= bus.sample;
            end

            if (start_frame) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 1'b1;
            end

            // A fresh frame clears a drop seen in the same cycle as its start.
            if (start_frame) begin
                overrun_q <= 1'b0;
                started_q <= 1'b1;
            end else if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.ena          = wea_q;
    assign bus.wea          = wea_q;
    assign bus.addra        = addra_q;
    assign bus.dina         = dina_q;
    assign bus.count        = count_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_ecg_bram_writer.sv
// Bench for ecg_bram_writer: two instances (8-sample frame at 0, 4-sample frame at 4094) against a frame-level model.
module tb_ecg_bram_writer;
    import ecg_pkg::*;

    localparam int FL0 = 8;
    localparam int BA0 = 0;
    localparam int FL1 = 4;
    localparam int BA1 = 4094;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ecg_bram_writer_if if0 ();
    ecg_bram_writer_if if1 ();

    ecg_bram_writer #(.FRAME_LEN(FL0), .BASE_ADDR(BA0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    ecg_bram_writer #(.FRAME_LEN(FL1), .BASE_ADDR(BA1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Port-B view of the two memories, filled from the port-A strobes.
    logic [31:0] mem0 [ECG_DEPTH];
    logic [31:0] mem1 [ECG_DEPTH];
    always @(posedge clk) begin
        if (if0.ena && if0.wea) mem0[if0.addra] <= if0.dina;
        if (if1.ena && if1.wea) mem1[if1.addra] <= if1.dina;
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          capturing;
        bit          finishing;
        int          accepted;
        bit          ever_started;
        bit          ovr;
        bit          wr;
        bit          done;
        int          addr;
        logic [31:0] dat;
    } mdl_t;

    typedef logic [62:0] vec_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{default: 0};
        return r;
    endfunction

    // Frame-level rules: what the outputs must show one clock after these inputs.
    function automatic mdl_t step(mdl_t m, logic st, logic ab, logic v, logic [31:0] s, int flen, int base);
        mdl_t n;
        bit   acc;
        bit   last;
        n    = m;
        acc  = m.capturing && v;
        last = acc && (m.accepted + 1 == flen);
        n.wr   = acc;
        n.done = m.finishing && !ab;
        if (acc) begin
            n.addr     = (base + m.accepted) % ECG_DEPTH;
            n.dat      = s;
            n.accepted = m.accepted + 1;
        end
        if (!m.capturing && v && m.ever_started) n.ovr = 1'b1;
        if (m.capturing) begin
            n.capturing = !ab && !last;
            n.finishing = !ab && last;
        end else if (m.finishing) begin
            n.finishing = 1'b0;
        end else if (st && !ab) begin
            n.capturing    = 1'b1;
            n.accepted     = 0;
            n.ovr          = 1'b0;
            n.ever_started = 1'b1;
        end
        return n;
    endfunction

    function automatic vec_t exp_vec(mdl_t m);
        return {m.capturing, m.capturing | m.finishing, m.done, m.ovr, m.wr, m.wr,
                13'(m.accepted), 12'(m.addr), m.dat};
    endfunction

    function automatic vec_t obs0();
        return {if0.sample_ready, if0.busy, if0.done, if0.overrun, if0.ena, if0.wea,
                if0.count, if0.addra, if0.dina};
    endfunction

    function automatic vec_t obs1();
        return {if1.sample_ready, if1.busy, if1.done, if1.overrun, if1.ena, if1.wea,
                if1.count, if1.addra, if1.dina};
    endfunction

    task automatic set0(logic st, logic ab, logic v, logic [31:0] s);
        if0.start = st; if0.abort = ab; if0.sample_valid = v; if0.sample = s;
    endtask

    task automatic set1(logic st, logic ab, logic v, logic [31:0] s);
        if1.start = st; if1.abort = ab; if1.sample_valid = v; if1.sample = s;
    endtask

    task automatic tick();
        m0 = step(m0, if0.start, if0.abort, if0.sample_valid, if0.sample, FL0, BA0);
        m1 = step(m1, if1.start, if1.abort, if1.sample_valid, if1.sample, FL1, BA1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        m0 = mdl_reset(); m1 = mdl_reset();
        #2;
        tests++;
        if (obs0() !== '0) begin fails++; $display("FAIL reset0: dut %h, want 0", obs0()); end
        tests++;
        if (obs1() !== '0) begin fails++; $display("FAIL reset1: dut %h, want 0", obs1()); end
        @(posedge clk); #3;
        rst = 1'b0;
        // Samples offered before any Start are not overruns.
        for (int k = 0; k < 3; k++) begin
            set0(0, 0, 1, $urandom); tick();
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL prestart cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
        end
        set0(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int last_wea = -1, done_k = -1, done_n = 0;
        set0(1, 0, 0, 0); tick();
        for (int k = 0; k < 13; k++) begin
            if (k < 8) set0(0, 0, 1, 32'hA0 + 32'(k)); else set0(0, 0, 0, 0);
            tick();
            if (if0.wea) last_wea = k;
            if (if0.done) begin done_k = k; done_n++; end
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL b2b cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
        end
        tests++;
        if (done_n != 1 || done_k != last_wea + 1) begin
            fails++; $display("FAIL b2b_done: pulses %0d at %0d, want 1 at %0d", done_n, done_k, last_wea + 1);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem0[i] !== 32'hA0 + 32'(i)) begin
                fails++; $display("FAIL b2b_mem[%0d]: got %h, want %h", i, mem0[i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_gapped();
        logic [31:0] q[$];
        int          done_n = 0;
        logic        v;
        logic [31:0] s;
        set0(1, 0, 0, 0); tick();
        for (int k = 0; k < 30; k++) begin
            v = (k % 3 == 0) && m0.capturing;
            s = $urandom;
            if (v) q.push_back(s);
            set0(0, 0, v, s); tick();
            if (if0.done) done_n++;
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL gapped cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
        end
        set0(0, 0, 0, 0);
        tests++;
        if (done_n != 1 || q.size() != FL0) begin
            fails++; $display("FAIL gapped_done: pulses %0d samples %0d, want 1 and %0d", done_n, q.size(), FL0);
        end
        for (int i = 0; i < q.size(); i++) begin
            tests++;
            if (mem0[i] !== q[i]) begin
                fails++; $display("FAIL gapped_mem[%0d]: got %h, want %h", i, mem0[i], q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] s;
        int          a;
        set1(1, 0, 0, 0); tick();
        for (int k = 0; k < 8; k++) begin
            s = $urandom;
            if (k < FL1) begin set1(0, 0, 1, s); q.push_back(s); end
            else set1(0, 0, 0, 0);
            tick();
            tests++;
            if (obs1() !== exp_vec(m1)) begin
                fails++; $display("FAIL wrap cyc %0d: dut %h, want %h", k, obs1(), exp_vec(m1));
            end
        end
        for (int i = 0; i < FL1; i++) begin
            a = (BA1 + i) % ECG_DEPTH;
            tests++;
            if (mem1[a] !== q[i]) begin
                fails++; $display("FAIL wrap_mem[%0d]: got %h, want %h", a, mem1[a], q[i]);
            end
        end
        tests++;
        if (if1.overrun !== 1'b0) begin fails++; $display("FAIL wrap_ovr: got %b, want 0", if1.overrun); end
    endtask

    task automatic test_overrun();
        set0(0, 0, 1, $urandom); tick();
        tests++;
        if (if0.overrun !== 1'b1 || if0.wea !== 1'b0) begin
            fails++; $display("FAIL ovr_set: overrun %b wea %b, want 1 0", if0.overrun, if0.wea);
        end
        set0(0, 0, 0, 0); tick();
        tests++;
        if (obs0() !== exp_vec(m0)) begin fails++; $display("FAIL ovr_sticky: dut %h, want %h", obs0(), exp_vec(m0)); end
        set0(1, 0, 0, 0); tick();
        tests++;
        if (obs0() !== exp_vec(m0)) begin fails++; $display("FAIL ovr_clear: dut %h, want %h", obs0(), exp_vec(m0)); end
        set0(0, 1, 0, 0); tick();
        set0(0, 0, 0, 0);
    endtask

    task automatic test_abort();
        logic v_ab;
        v_ab = 1'($urandom);
        set0(1, 0, 0, 0); tick();
        for (int k = 0; k < 6; k++) begin
            if (k < 3) set0(0, 0, 1, $urandom);
            else if (k == 3) set0(0, 1, v_ab, $urandom);
            else set0(0, 0, 0, 0);
            tick();
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL abort cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
            if (k == 3) begin
                tests++;
                if (if0.busy !== 1'b0 || int'(if0.count) != 3 + int'(v_ab)) begin
                    fails++; $display("FAIL abort_cnt: busy %b count %0d, want 0 %0d", if0.busy, if0.count, 3 + int'(v_ab));
                end
            end
        end
        set0(1, 1, 0, 0); tick();
        tests++;
        if (obs0() !== exp_vec(m0) || if0.busy !== 1'b0) begin
            fails++; $display("FAIL start_abort: dut %h, want %h", obs0(), exp_vec(m0));
        end
        set0(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set0(($urandom % 16) == 0, ($urandom % 32) == 0, 1'($urandom), $urandom);
            set1(($urandom % 12) == 0, ($urandom % 32) == 0, 1'($urandom), $urandom);
            tick();
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL rand0 cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
            tests++;
            if (obs1() !== exp_vec(m1)) begin
                fails++; $display("FAIL rand1 cyc %0d: dut %h, want %h", k, obs1(), exp_vec(m1));
            end
        end
        set0(0, 1, 0, 0); set1(0, 1, 0, 0); tick(); tick();
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        set0(1, 0, 0, 0); set1(1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            set0(0, 0, 1, $urandom); set1(0, 0, 1, $urandom); tick();
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (obs0() !== '0) begin fails++; $display("FAIL arst0: dut %h, want 0", obs0()); end
        tests++;
        if (obs1() !== '0) begin fails++; $display("FAIL arst1: dut %h, want 0", obs1()); end
        m0 = mdl_reset(); m1 = mdl_reset();
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        @(posedge clk); #1;
        tests++;
        if (obs0() !== '0) begin fails++; $display("FAIL arst_hold: dut %h, want 0", obs0()); end
        rst = 1'b0;
        set0(1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            set0(0, 0, 1, $urandom); tick();
            tests++;
            if (obs0() !== exp_vec(m0)) begin
                fails++; $display("FAIL restart cyc %0d: dut %h, want %h", k, obs0(), exp_vec(m0));
            end
            if (k == 0) begin
                tests++;
                if (if0.addra !== 12'(BA0) || if0.wea !== 1'b1) begin
                    fails++; $display("FAIL restart_addr: addra %0d wea %b, want %0d 1", if0.addra, if0.wea, BA0);
                end
            end
        end
        set0(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_wrap();
        test_overrun();
        test_abort();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
